// File: rtl/sram16_bridge.sv
// sram16_bridge: turns single-cycle 32-bit CPU memory requests into two
// 16-bit accesses on an asynchronous SRAM. The upper halfword is accessed first
// (HI), then the lower halfword (LO). Each half lasts WAIT_CYCLES strobe cycles
// plus one hold cycle. Every output comes straight from a flop, so the SRAM
// pins stay glitch-free.
module sram16_bridge #(
  parameter int WAIT_CYCLES = 1  // strobe-active cycles per half, 1..8
) (
  input  logic        clk,
  input  logic        reset,       // asynchronous, active-low
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [19:0] sram_adr,
  output logic [15:0] sram_dq_out,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_in,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HI   = 2'd1,
    LO   = 2'd2,
    DONE = 2'd3
  } state_t;

  // All SRAM control pins, kept together so a phase entry sets them in one go.
  typedef struct packed {
    logic ce_n;
    logic oe_n;
    logic we_n;
    logic ub_n;
    logic lb_n;
    logic dq_oe;
  } strobe_t;

  localparam strobe_t STROBES_OFF = '{
    ce_n: 1'b1, oe_n: 1'b1, we_n: 1'b1, ub_n: 1'b1, lb_n: 1'b1, dq_oe: 1'b0
  };

  // The phase counter reloads to WAIT_CYCLES and counts down to zero. The
  // zero cycle is the hold cycle, and its closing edge ends the phase.
  localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

  // Strobe values for the first cycle of a half-access.
  // A write whose two byte enables for this half are both clear keeps we_n
  // high. The phase still runs its full length, so latency does not change.
  // A read enables both byte lanes and the output buffers, and never drives
  // the bus.
  function automatic strobe_t phase_strobes(input logic we, input logic [1:0] be_half);
    strobe_t s;
    s.ce_n = 1'b0;
    if (we) begin
      s.oe_n  = 1'b1;
      s.we_n  = ~|be_half;
      s.ub_n  = ~be_half[1];
      s.lb_n  = ~be_half[0];
      s.dq_oe = 1'b1;
    end else begin
      s.oe_n  = 1'b0;
      s.we_n  = 1'b1;
      s.ub_n  = 1'b0;
      s.lb_n  = 1'b0;
      s.dq_oe = 1'b0;
    end
    return s;
  endfunction

  state_t      state_q;
  logic [3:0]  cnt_q;
  strobe_t     strb_q;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic [19:0] sram_adr_q;
  logic [15:0] sram_dq_out_q;

  // The request is captured at acceptance. Only the parts still needed after
  // the HI entry are kept.
  logic        we_q;
  logic [17:0] word_adr_q;   // req_addr[19:2]
  logic [15:0] wdata_lo_q;   // req_wdata[15:0], driven during LO
  logic [1:0]  be_lo_q;      // req_be[1:0], used during LO
  logic [15:0] hi_sample_q;  // upper read halfword, held until LO completes

  // Address bits outside the 1 MiB halfword space and the byte offset have no
  // meaning on this bus.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{req_addr[31:20], req_addr[1:0]};

  // Sequencer: request handshake, phase timing, SRAM strobes and response.
  // NOTE: every flop here uses non-blocking assignments, so each branch reads
  // the values from before this edge, whatever order the statements are in.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      cnt_q         <= 4'd0;
      strb_q        <= STROBES_OFF;
      req_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= 32'd0;
      sram_adr_q    <= 20'd0;
      sram_dq_out_q <= 16'd0;
      we_q          <= 1'b0;
      word_adr_q    <= 18'd0;
      wdata_lo_q    <= 16'd0;
      be_lo_q       <= 2'd0;
      hi_sample_q   <= 16'd0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid && req_ready_q) begin
            state_q       <= HI;
            cnt_q         <= WAIT_LD;
            req_ready_q   <= 1'b0;
            we_q          <= req_we;
            word_adr_q    <= req_addr[19:2];
            wdata_lo_q    <= req_wdata[15:0];
            be_lo_q       <= req_be[1:0];
            sram_adr_q    <= {req_addr[19:2], 1'b0, 1'b0};
            sram_dq_out_q <= req_wdata[31:16];
            strb_q        <= phase_strobes(req_we, req_be[3:2]);
          end else begin
            req_ready_q <= 1'b1;
          end
        end

        HI: begin
          if (cnt_q == 4'd0) begin
            if (!we_q) begin
              hi_sample_q <= sram_dq_in;
            end
            state_q       <= LO;
            cnt_q         <= WAIT_LD;
            sram_adr_q    <= {word_adr_q, 1'b1, 1'b0};
            sram_dq_out_q <= wdata_lo_q;
            strb_q        <= phase_strobes(we_q, be_lo_q);
          end else begin
            cnt_q <= cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
              strb_q.we_n <= 1'b1;  // the hold cycle has we_n released
            end
          end
        end

        LO: begin
          if (cnt_q == 4'd0) begin
            if (!we_q) begin
              rsp_rdata_q <= {hi_sample_q, sram_dq_in};
            end
            state_q     <= DONE;
            rsp_valid_q <= 1'b1;
            strb_q      <= STROBES_OFF;
          end else begin
            cnt_q <= cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
              strb_q.we_n <= 1'b1;
            end
          end
        end

        DONE: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
        end

        default: begin
          state_q <= IDLE;
          strb_q  <= STROBES_OFF;
        end
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign sram_adr    = sram_adr_q;
  assign sram_dq_out = sram_dq_out_q;
  assign sram_dq_oe  = strb_q.dq_oe;
  assign sram_ce_n   = strb_q.ce_n;
  assign sram_oe_n   = strb_q.oe_n;
  assign sram_we_n   = strb_q.we_n;
  assign sram_ub_n   = strb_q.ub_n;
  assign sram_lb_n   = strb_q.lb_n;

endmodule

// File: tb/tb_sram16_bridge.sv
// Testbench for sram16_bridge. Two bridges are built, one with WAIT_CYCLES=1
// and one with WAIT_CYCLES=3. Each has its own halfword SRAM model. A
// word-level reference memory predicts read data. Each transaction's pin
// activity is compared cycle by cycle with the timing the bridge must produce.
module tb_sram16_bridge;

  localparam int W0 = 1;
  localparam int W1 = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic [3:0]  req_be    [2];
  logic        rsp_valid [2];
  logic [31:0] rsp_rdata [2];
  logic [19:0] sram_adr  [2];
  logic [15:0] dq_out    [2];
  logic [15:0] dq_in     [2];
  logic        dq_oe     [2];
  logic        ce_n      [2];
  logic        oe_n      [2];
  logic        we_n      [2];
  logic        ub_n      [2];
  logic        lb_n      [2];

  logic [15:0] mem     [2][2048];  // SRAM model: halfwords
  logic [31:0] ref_mem [2][1024];  // reference: 32-bit words
  logic [31:0] last_rd [2];        // expected held value of rsp_rdata

  int total = 0;
  int bad   = 0;

  sram16_bridge #(.WAIT_CYCLES(W0)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]),
    .sram_adr(sram_adr[0]), .sram_dq_out(dq_out[0]), .sram_dq_oe(dq_oe[0]),
    .sram_dq_in(dq_in[0]), .sram_ce_n(ce_n[0]), .sram_oe_n(oe_n[0]),
    .sram_we_n(we_n[0]), .sram_ub_n(ub_n[0]), .sram_lb_n(lb_n[0])
  );

  sram16_bridge #(.WAIT_CYCLES(W1)) dut1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]),
    .sram_adr(sram_adr[1]), .sram_dq_out(dq_out[1]), .sram_dq_oe(dq_oe[1]),
    .sram_dq_in(dq_in[1]), .sram_ce_n(ce_n[1]), .sram_oe_n(oe_n[1]),
    .sram_we_n(we_n[1]), .sram_ub_n(ub_n[1]), .sram_lb_n(lb_n[1])
  );

  // The SRAM drives the bus only while it is selected with its outputs enabled.
  assign dq_in[0] = (!ce_n[0] && !oe_n[0]) ? mem[0][sram_adr[0][11:1]] : 16'hxxxx;
  assign dq_in[1] = (!ce_n[1] && !oe_n[1]) ? mem[1][sram_adr[1][11:1]] : 16'hxxxx;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // SRAM model writes on each selected edge with we_n low, per byte lane.
  // It also watches the bus for contention.
  always @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      check($sformatf("dut%0d_no_bus_contention", s), {63'd0, dq_oe[s] & ~oe_n[s]}, 64'd0);
      if (!ce_n[s] && !we_n[s]) begin
        if (!ub_n[s]) mem[s][sram_adr[s][11:1]][15:8] <= dq_out[s][15:8];
        if (!lb_n[s]) mem[s][sram_adr[s][11:1]][7:0]  <= dq_out[s][7:0];
      end
    end
  end

  // Pin state that reset forces: ready/rsp low, strobes high, bus released.
  function automatic logic [43:0] pin_vec(input int s);
    return {req_ready[s], rsp_valid[s], ce_n[s], oe_n[s], we_n[s], ub_n[s],
            lb_n[s], dq_oe[s], sram_adr[s], dq_out[s]};
  endfunction

  localparam logic [43:0] RESET_PINS = {8'b0011_1110, 20'd0, 16'd0};

  // Runs one request on bridge s, starting just after a falling clock edge.
  // The first cycle after acceptance is cycle 1. If hold is set, req_valid
  // stays high for a follow-on request. If expect_now is set, the request must
  // be accepted at the very next edge.
  task automatic txn(input int s, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be,
                     input bit hold, input bit expect_now);
    int          w;
    int          lat;
    int          waited;
    int          pos;
    logic        lo;
    logic [1:0]  bh;
    logic [31:0] exp_rd;
    logic [31:0] junk;
    logic [43:0] obs;
    logic [43:0] exp;
    logic        e_oe_n, e_we_n, e_ub, e_lb, e_dqoe;
    logic [15:0] e_dq;
    w      = (s == 0) ? W0 : W1;
    lat    = 2 * (w + 1) + 1;
    waited = 0;
    exp_rd = ref_mem[s][addr[11:2]];
    if (we) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) ref_mem[s][addr[11:2]][8*b +: 8] = wdata[8*b +: 8];
    end

    req_valid[s] = 1'b1;
    req_we[s]    = we;
    req_addr[s]  = addr;
    req_wdata[s] = wdata;
    req_be[s]    = be;
    while (req_ready[s] !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check($sformatf("dut%0d_accept_ready", s), {63'd0, req_ready[s]}, 64'd1);
    if (expect_now) check($sformatf("dut%0d_b2b_accept_gap", s), 64'(waited), 64'd0);
    if (req_ready[s] !== 1'b1) begin
      req_valid[s] = 1'b0;
      return;
    end

    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (k == 1 && !hold) begin
        // The bridge must ignore anything on the request port from now on.
        req_valid[s] = 1'b0;
        junk         = $urandom;
        req_we[s]    = junk[0];
        req_addr[s]  = $urandom;
        req_wdata[s] = $urandom;
        req_be[s]    = junk[7:4];
      end
      if (k < lat) begin
        lo  = (k > w + 1);
        pos = (k - 1) % (w + 1);
        bh  = lo ? be[1:0] : be[3:2];
        if (we) begin
          e_oe_n = 1'b1;
          e_we_n = (bh != 2'b00 && pos < w) ? 1'b0 : 1'b1;
          e_ub   = ~bh[1];
          e_lb   = ~bh[0];
          e_dqoe = 1'b1;
          e_dq   = lo ? wdata[15:0] : wdata[31:16];
        end else begin
          e_oe_n = 1'b0;
          e_we_n = 1'b1;
          e_ub   = 1'b0;
          e_lb   = 1'b0;
          e_dqoe = 1'b0;
          e_dq   = 16'd0;
        end
        obs = {rsp_valid[s], req_ready[s], ce_n[s], oe_n[s], we_n[s], ub_n[s],
               lb_n[s], dq_oe[s], sram_adr[s], we ? dq_out[s] : 16'd0};
        exp = {1'b0, 1'b0, 1'b0, e_oe_n, e_we_n, e_ub, e_lb, e_dqoe,
               addr[19:2], lo, 1'b0, e_dq};
        check($sformatf("dut%0d_%s_cycle%0d", s, lo ? "lo" : "hi", k), 64'(obs), 64'(exp));
      end else begin
        check($sformatf("dut%0d_done_cycle%0d", s, k),
              {59'd0, rsp_valid[s], req_ready[s], ce_n[s], we_n[s], dq_oe[s]},
              {59'd0, 5'b10110});
        if (!we) last_rd[s] = exp_rd;
        check($sformatf("dut%0d_rdata", s), 64'(rsp_rdata[s]), 64'(last_rd[s]));
      end
    end

    @(negedge clk);
    check($sformatf("dut%0d_idle_after_done", s),
          {62'd0, rsp_valid[s], req_ready[s]}, 64'd1);
    check($sformatf("dut%0d_rdata_held", s), 64'(rsp_rdata[s]), 64'(last_rd[s]));
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] a;
    int          s;
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0;
      req_we[i]    = 1'b0;
      req_addr[i]  = 32'd0;
      req_wdata[i] = 32'd0;
      req_be[i]    = 4'd0;
      last_rd[i]   = 32'd0;
    end
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 1024; j++) begin
        r = $urandom;
        mem[i][2*j]     <= r[31:16];
        mem[i][2*j + 1] <= r[15:0];
        ref_mem[i][j]    = r;
      end
    end

    // Reset held across clock edges.
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("dut%0d_reset_pins", i), 64'(pin_vec(i)), 64'(RESET_PINS));
      check($sformatf("dut%0d_reset_rdata", i), 64'(rsp_rdata[i]), 64'd0);
    end
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 2; i++)
      check($sformatf("dut%0d_ready_after_release", i), {63'd0, req_ready[i]}, 64'd1);

    // Full write of 0xDEADBEEF at 0x10 with one strobe cycle per half.
    txn(0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 1'b0);
    check("sram_hi_half_0x10", 64'(mem[0][8]), 64'h0000_DEAD);
    check("sram_lo_half_0x12", 64'(mem[0][9]), 64'h0000_BEEF);

    // Read from 0x1234@0x10 and 0x5678@0x12.
    mem[0][8]     <= 16'h1234;
    mem[0][9]     <= 16'h5678;
    ref_mem[0][4]  = 32'h1234_5678;
    txn(0, 1'b0, 32'h0000_0010, 32'h0, 4'h0, 1'b0, 1'b0);
    check("read_0x10_word", 64'(rsp_rdata[0]), 64'h1234_5678);

    // be=0100 with ignored address bits set: HI writes the lower byte only,
    // and LO keeps we_n high.
    txn(0, 1'b1, 32'hABC0_0023, 32'h0102_0304, 4'b0100, 1'b0, 1'b0);
    txn(0, 1'b0, 32'h0000_0020, 32'h0, 4'h0, 1'b0, 1'b0);

    // Three wait cycles, with req_valid held high across two requests.
    txn(1, 1'b1, 32'h0000_0040, 32'hCAFE_F00D, 4'hF, 1'b1, 1'b0);
    txn(1, 1'b0, 32'h0000_0040, 32'h0, 4'h0, 1'b0, 1'b1);

    // Random traffic over a small window, so that reads hit earlier writes.
    for (int i = 0; i < 40; i++) begin
      s = $urandom_range(1, 0);
      r = $urandom;
      a = {r[31:20], 12'h000, r[7:0]};
      txn(s, 1'($urandom_range(1, 0)), a, $urandom, 4'($urandom), 1'b0, 1'b0);
    end

    // Reset dropped in the middle of the LO phase of a write.
    req_valid[1] = 1'b1;
    req_we[1]    = 1'b1;
    req_addr[1]  = 32'h0000_0100;
    req_wdata[1] = 32'h5555_AAAA;
    req_be[1]    = 4'hF;
    check("abort_ready_before", {63'd0, req_ready[1]}, 64'd1);
    @(negedge clk);
    req_valid[1] = 1'b0;
    repeat (W1 + 1) @(negedge clk);
    check("abort_in_lo_strobing", {62'd0, ce_n[1], we_n[1]}, 64'd0);
    #2;
    reset = 1'b0;
    #1;
    check("abort_async_pins", 64'(pin_vec(1)), 64'(RESET_PINS));
    check("abort_async_rdata", 64'(rsp_rdata[1]), 64'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("abort_no_rsp_%0d", k), {63'd0, rsp_valid[1]}, 64'd0);
    end
    reset = 1'b1;
    last_rd[0] = 32'd0;
    last_rd[1] = 32'd0;
    @(negedge clk);
    check("abort_ready_after_release", {62'd0, req_ready[1], rsp_valid[1]}, 64'd2);

    // The aborted write may have reached the SRAM. Rewrite the word, then
    // check that the bridge still works.
    txn(1, 1'b1, 32'h0000_0100, 32'h1357_9BDF, 4'hF, 1'b0, 1'b0);
    txn(1, 1'b0, 32'h0000_0100, 32'h0, 4'h0, 1'b0, 1'b0);
    check("post_abort_read", 64'(rsp_rdata[1]), 64'h1357_9BDF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
